rf_writeback_arbiter: RTL and testbench

- Owns the single register-file write port (we/rd/data) and produces the pending-register status that the decode stage uses for stalls.
- Merges two sources:
  - the in-order pipeline WB result, which is fixed-latency and never back-pressured;
  - completions from long-latency units (divider, multi-cycle loads), which use a valid/ready handshake.
- Long-latency completions are buffered in a small FIFO.
- A scoreboard tracks destination registers that have been issued to long-latency units but not yet written.

---
 rtl/rf_writeback_arbiter_pkg.sv | 13 +
 rtl/rf_writeback_arbiter_wb_fifo.sv | 56 +++++
 rtl/rf_writeback_arbiter.sv | 127 ++++++++++++
 tb/tb_rf_writeback_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_writeback_arbiter_pkg.sv
// rtl/rf_writeback_arbiter_pkg.sv - shared widths and the writeback entry type
package rf_writeback_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int REG_SIZE = 32;
  localparam int REG_AW   = $clog2(REG_SIZE);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/rf_writeback_arbiter_wb_fifo.sv
// rtl/rf_writeback_arbiter_wb_fifo.sv - DEPTH-entry synchronous FIFO of writeback entries
module rf_writeback_arbiter_wb_fifo
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                push_data,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t     mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// rtl/rf_writeback_arbiter.sv - register-file write port arbiter with long-latency scoreboard
module rf_writeback_arbiter
  import rf_writeback_arbiter_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_we,
  input  logic [REG_AW-1:0] pipe_rd,
  input  logic [XLEN-1:0]   pipe_data,
  input  logic              mc_valid,
  output logic              mc_ready,
  input  logic [REG_AW-1:0] mc_rd,
  input  logic [XLEN-1:0]   mc_data,
  input  logic              issue_valid,
  input  logic [REG_AW-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [REG_AW-1:0] rs1,
  input  logic [REG_AW-1:0] rs2,
  output logic              rs1_pending,
  output logic              rs2_pending,
  output logic              wb_stall_req,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_rd,
  output logic [XLEN-1:0]   rf_wdata
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic                pipe_act;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  wb_entry_t           fifo_head;
  wb_entry_t           mc_entry;
  logic [REG_SIZE-1:0] pending;
  logic [REG_SIZE-1:0] pending_next;
  logic                issue_set;
  logic [SW-1:0]       starve_cnt;

  assign pipe_act = pipe_we && (pipe_rd != '0);

  // The pipeline result always wins the port; the FIFO only drains in idle WB slots.
  assign fifo_pop  = !rst && !pipe_act && !fifo_empty;
  assign mc_ready  = !rst && (!fifo_full || fifo_pop);
  assign fifo_push = mc_valid && mc_ready && (mc_rd != '0);
  assign mc_entry  = '{rd: mc_rd, data: mc_data};

  rf_writeback_arbiter_wb_fifo #(
    .DEPTH(DEPTH)
  ) u_wb_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (mc_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_wdata = '0;
    if (!rst) begin
      if (pipe_act) begin
        rf_we    = 1'b1;
        rf_rd    = pipe_rd;
        rf_wdata = pipe_data;
      end else if (!fifo_empty) begin
        rf_we    = 1'b1;
        rf_rd    = fifo_head.rd;
        rf_wdata = fifo_head.data;
      end
    end
  end

  assign issue_ready = !pending[issue_rd] || (issue_rd == '0);
  assign issue_set   = issue_valid && issue_ready && (issue_rd != '0);
  assign rs1_pending = pending[rs1];
  assign rs2_pending = pending[rs2];

  // Set is applied after clear so a re-issue during the retiring write stays pending.
  always_comb begin
    pending_next = pending;
    if (fifo_pop) begin
      pending_next[fifo_head.rd] = 1'b0;
    end
    if (issue_set) begin
      pending_next[issue_rd] = 1'b1;
    end
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !(fifo_full && pipe_act)) begin
      starve_cnt <= '0;
    end else if (starve_cnt != SW'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  assign wb_stall_req = !rst && (starve_cnt == SW'(STARVE_LIMIT));

  // Writing a register that still awaits a long-latency result means decode missed a stall.
  a_pipe_wr_pending : assert property (@(posedge clk) disable iff (rst)
    !(pipe_act && pending[pipe_rd]));

  a_fifo_count_range : assert property (@(posedge clk) disable iff (rst)
    fifo_count <= CW'(DEPTH));

endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb/tb_rf_writeback_arbiter.sv - self-checking bench for rf_writeback_arbiter
module tb_rf_writeback_arbiter;
  import rf_writeback_arbiter_pkg::*;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              pipe_we;
  logic [REG_AW-1:0] pipe_rd;
  logic [XLEN-1:0]   pipe_data;
  logic              mc_valid;
  logic              mc_ready;
  logic [REG_AW-1:0] mc_rd;
  logic [XLEN-1:0]   mc_data;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic              issue_ready;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              rs1_pending;
  logic              rs2_pending;
  logic              wb_stall_req;
  logic              rf_we;
  logic [REG_AW-1:0] rf_rd;
  logic [XLEN-1:0]   rf_wdata;

  int total = 0;
  int bad   = 0;

  rf_writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1(rs1), .rs2(rs2), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
    .wb_stall_req(wb_stall_req),
    .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    pipe_we = 0; pipe_rd = 0; pipe_data = 0;
    mc_valid = 0; mc_rd = 0; mc_data = 0;
    issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard model: completions queued when accepted, popped when the port is free.
  wb_entry_t   q[$];
  logic [31:0] m_pend = '0;
  int          m_cnt  = 0;

  always @(negedge clk) begin : model_blk
    logic        m_act;
    logic        m_pop;
    logic        m_ready;
    logic        m_iss_ok;
    logic [37:0] exp_rf;
    if (rst) begin
      check("rst_outputs", 64'({mc_ready, rf_we, wb_stall_req}), 64'(3'b000));
      q.delete();
      m_pend = '0;
      m_cnt  = 0;
    end else begin
      m_act    = pipe_we && (pipe_rd != 0);
      m_pop    = !m_act && (q.size() > 0);
      m_ready  = (q.size() < DEPTH) || m_pop;
      m_iss_ok = !m_pend[issue_rd] || (issue_rd == 0);
      check("sb_mc_ready", 64'(mc_ready), 64'(m_ready));
      check("sb_stall", 64'(wb_stall_req), 64'(m_cnt == STARVE_LIMIT));
      check("sb_status", 64'({rs1_pending, rs2_pending, issue_ready}),
            64'({m_pend[rs1], m_pend[rs2], m_iss_ok}));
      if (m_act)      exp_rf = {1'b1, pipe_rd, pipe_data};
      else if (m_pop) exp_rf = {1'b1, q[0].rd, q[0].data};
      else            exp_rf = '0;
      check("sb_rf", 64'({rf_we, rf_rd, rf_wdata}), 64'(exp_rf));
      if ((q.size() == DEPTH) && m_act) m_cnt = (m_cnt < STARVE_LIMIT) ? m_cnt + 1 : m_cnt;
      else                              m_cnt = 0;
      if (m_pop) begin
        m_pend[q[0].rd] = 1'b0;
        void'(q.pop_front());
      end
      if (issue_valid && m_iss_ok && (issue_rd != 0)) m_pend[issue_rd] = 1'b1;
      if (mc_valid && m_ready && (mc_rd != 0)) q.push_back('{rd: mc_rd, data: mc_data});
    end
  end

  typedef struct {
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        mc_valid;
    logic [4:0]  mc_rd;
    logic [31:0] mc_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_mc_ready;
    logic        e_issue_ready;
    logic        e_rs1p;
    logic        e_rs2p;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 0, 0,             0, 0,  0,            0, 0,  0,  0,  0, 0,  0,            1, 1, 0, 0};
    vecs[1] = '{0, 0, 0,             0, 0,  0,            1, 12, 12, 0,  0, 0,  0,            1, 1, 0, 0};
    vecs[2] = '{0, 0, 0,             0, 0,  0,            1, 12, 12, 12, 0, 0,  0,            1, 0, 1, 1};
    vecs[3] = '{1, 3, 32'hAA,        1, 12, 32'h1212,     0, 12, 12, 0,  1, 3,  32'hAA,       1, 0, 1, 0};
    vecs[4] = '{0, 0, 0,             0, 0,  0,            0, 12, 12, 0,  1, 12, 32'h1212,     1, 0, 1, 0};
    vecs[5] = '{0, 0, 0,             0, 0,  0,            0, 12, 12, 0,  0, 0,  0,            1, 1, 0, 0};
    vecs[6] = '{1, 0, 32'hDEAD,      1, 0,  32'hBEEF,     1, 0,  0,  0,  0, 0,  0,            1, 1, 0, 0};
    vecs[7] = '{0, 0, 0,             0, 0,  0,            0, 0,  0,  0,  0, 0,  0,            1, 1, 0, 0};

    idle();
    rst = 1;
    nxt(); nxt();
    rst = 0;

    for (int i = 0; i < 8; i++) begin
      pipe_we = vecs[i].pipe_we; pipe_rd = vecs[i].pipe_rd; pipe_data = vecs[i].pipe_data;
      mc_valid = vecs[i].mc_valid; mc_rd = vecs[i].mc_rd; mc_data = vecs[i].mc_data;
      issue_valid = vecs[i].issue_valid; issue_rd = vecs[i].issue_rd;
      rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
      @(negedge clk);
      check($sformatf("vec%0d_rf", i), 64'({rf_we, rf_rd, rf_wdata}),
            64'({vecs[i].e_we, vecs[i].e_rd, vecs[i].e_data}));
      check($sformatf("vec%0d_ready", i), 64'({mc_ready, issue_ready}),
            64'({vecs[i].e_mc_ready, vecs[i].e_issue_ready}));
      check($sformatf("vec%0d_pend", i), 64'({rs1_pending, rs2_pending}),
            64'({vecs[i].e_rs1p, vecs[i].e_rs2p}));
      nxt();
    end

    // Same-cycle issue and retiring write of x12: set wins.
    idle(); mc_valid = 1; mc_rd = 12; mc_data = 32'h7777;
    nxt();
    idle(); issue_valid = 1; issue_rd = 12;
    @(negedge clk);
    check("setwin_rf", 64'({rf_we, rf_rd, rf_wdata}), 64'({1'b1, 5'd12, 32'h7777}));
    check("setwin_issue_ready", 64'(issue_ready), 64'(1));
    nxt();
    idle(); rs1 = 12; mc_valid = 1; mc_rd = 12; mc_data = 32'h8888;
    @(negedge clk);
    check("setwin_pend", 64'(rs1_pending), 64'(1));
    nxt();
    idle(); rs1 = 12;
    @(negedge clk);
    check("setwin_rf2", 64'({rf_we, rf_rd, rf_wdata}), 64'({1'b1, 5'd12, 32'h8888}));
    nxt();
    idle(); rs1 = 12;
    @(negedge clk);
    check("setwin_cleared", 64'(rs1_pending), 64'(0));
    nxt();

    // Pipe priority over a queued completion.
    idle(); issue_valid = 1; issue_rd = 9; mc_valid = 1; mc_rd = 9; mc_data = 32'h55;
    nxt();
    idle(); pipe_we = 1; pipe_rd = 3; pipe_data = 32'hAA; rs1 = 9;
    @(negedge clk);
    check("prio_pipe", 64'({rf_we, rf_rd, rf_wdata}), 64'({1'b1, 5'd3, 32'hAA}));
    check("prio_pend_n", 64'(rs1_pending), 64'(1));
    nxt();
    idle(); rs1 = 9;
    @(negedge clk);
    check("prio_fifo", 64'({rf_we, rf_rd, rf_wdata}), 64'({1'b1, 5'd9, 32'h55}));
    nxt();
    idle(); rs1 = 9;
    @(negedge clk);
    check("prio_pend_clr", 64'({rs1_pending, rf_we}), 64'(2'b00));
    nxt();

    // Back-pressure and starvation under continuous pipeline writes.
    idle(); pipe_we = 1; pipe_rd = 2; pipe_data = 32'h2222;
    for (int i = 0; i < 14; i++) begin
      mc_valid = 1;
      mc_rd    = (i < 4) ? 5'(21 + i) : 5'd25;
      mc_data  = (i < 4) ? 32'(32'hC000 + i) : 32'hC004;
      if (i == 13) pipe_we = 0;
      @(negedge clk);
      if (i < 4)   check($sformatf("bp_accept%0d", i), 64'(mc_ready), 64'(1));
      if (i == 4)  check("bp_full_ready", 64'(mc_ready), 64'(0));
      if (i == 11) check("starve_pre", 64'(wb_stall_req), 64'(0));
      if (i == 12) check("starve_req", 64'(wb_stall_req), 64'(1));
      if (i == 13) check("starve_pop", 64'({rf_we, rf_rd, mc_ready}), 64'({1'b1, 5'd21, 1'b1}));
      nxt();
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      if (j == 0) check("starve_clear", 64'(wb_stall_req), 64'(0));
      check($sformatf("drain%0d", j), 64'({rf_we, rf_rd, rf_wdata}),
            64'({1'b1, 5'(22 + j), 32'(32'hC001 + j)}));
      nxt();
    end
    @(negedge clk);
    check("drain_empty", 64'(rf_we), 64'(0));
    nxt();

    // Second fill crosses the pointer wrap.
    pipe_we = 1; pipe_rd = 2; pipe_data = 32'h3333;
    for (int i = 0; i < 4; i++) begin
      mc_valid = 1; mc_rd = 5'(26 + i); mc_data = 32'(32'hE000 + i);
      @(negedge clk);
      check($sformatf("wrap_accept%0d", i), 64'(mc_ready), 64'(1));
      nxt();
    end
    idle();
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check($sformatf("wrap_drain%0d", j), 64'({rf_we, rf_rd, rf_wdata}),
            64'({1'b1, 5'(26 + j), 32'(32'hE000 + j)}));
      nxt();
    end

    // Reset with three queued entries and x5..x7 pending.
    pipe_we = 1; pipe_rd = 1; pipe_data = 32'h1111;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1; issue_rd = 5'(5 + i);
      mc_valid = 1; mc_rd = 5'(5 + i); mc_data = 32'(32'hD0 + i);
      nxt();
    end
    rst = 1; mc_rd = 8; issue_rd = 10;
    @(negedge clk);
    check("rst_mid_out", 64'({mc_ready, rf_we, wb_stall_req}), 64'(3'b000));
    nxt();
    rst = 0; idle(); rs1 = 5; rs2 = 6; issue_rd = 7;
    @(negedge clk);
    check("rst_after", 64'({rf_we, mc_ready, rs1_pending, rs2_pending, issue_ready}), 64'(5'b01001));
    nxt();
    idle(); rs1 = 10; rs2 = 7;
    @(negedge clk);
    check("rst_discard", 64'({rf_we, rs1_pending, rs2_pending}), 64'(3'b000));
    nxt();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
